btb_ras_predictor: RTL

BTB_RAS_PREDICTOR -- requirements
Module: btb_ras_predictor

---
 rtl/btb_ras_predictor.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/btb_ras_predictor.sv
// Branch target buffer plus return-address stack with a one-cycle
// registered prediction; the package holds the fetch/execute bundles.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  pipeline flush (drops lookup, empties RAS)
//   fetch_valid_i/pc_i       lookup request and fetch PC
//   ras_push_i/addr_i        predecoded call and its return address
//   ras_pop_i                predecoded return
//   bju_i                    resolved control flow from execute
//   bpu_valid_o/bpu_o        registered prediction (cf, predict_addr)

package btb_ras_pkg;

    typedef enum logic [2:0] {
        CF_NONE   = 3'd0,
        CF_BRANCH = 3'd1,
        CF_JAL    = 3'd2,
        CF_JALR   = 3'd3,
        CF_RET    = 3'd4
    } cf_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] target_address;
        logic        is_mispredict;
        logic        is_taken;
        cf_t         cf;
    } bju_t;

    typedef struct packed {
        cf_t         cf;
        logic [31:0] predict_addr;
    } bpu_t;

endpackage

module btb_ras_predictor
    import btb_ras_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int RAS_DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        ras_push_i,
    input  logic [31:0] ras_push_addr_i,
    input  logic        ras_pop_i,
    input  bju_t        bju_i,
    output logic        bpu_valid_o,
    output bpu_t        bpu_o
);

    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = 31 - IDX;
    localparam int PW  = $clog2(RAS_DEPTH);
    localparam int CW  = PW + 1;

    // BTB storage
    logic            btb_vld_q [BTB_ENTRIES];
    logic [TW-1:0]   btb_tag_q [BTB_ENTRIES];
    cf_t             btb_cf_q  [BTB_ENTRIES];
    logic [31:0]     btb_tgt_q [BTB_ENTRIES];
    logic [1:0]      btb_cnt_q [BTB_ENTRIES];

    // RAS storage: ptr is the next free slot, top lives at ptr-1
    logic [31:0]     ras_q [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr_q, ras_ptr_d;
    logic [CW-1:0]   ras_cnt_q, ras_cnt_d;
    logic [PW-1:0]   ras_ptr_m1;
    logic            ras_we;
    logic [PW-1:0]   ras_waddr;

    // Registered prediction
    logic            bpu_valid_q, bpu_valid_d;
    bpu_t            bpu_q, bpu_d;
    bpu_t            pred;

    // Lookup side
    logic [IDX-1:0]  f_idx;
    logic [TW-1:0]   f_tag;
    logic            f_hit;

    // Update side
    logic [IDX-1:0]  b_idx;
    logic [TW-1:0]   b_tag;
    logic            b_hit;
    logic            b_br;
    logic            br_upd;
    logic            br_alloc;
    logic            ind_wr;
    logic [1:0]      cnt_nxt;

    // Bit 0 of a halfword-aligned PC carries no information
    logic            unused_pc_lsb;
    assign unused_pc_lsb = fetch_pc_i[0] ^ bju_i.pc[0];

    assign ras_ptr_m1 = ras_ptr_q - PW'(1);

    // ------------------------------------------------------------
    // Lookup: reads state as it stood before this edge
    // ------------------------------------------------------------
    assign f_idx = fetch_pc_i[IDX:1];
    assign f_tag = fetch_pc_i[31:IDX+1];
    assign f_hit = btb_vld_q[f_idx] && (btb_tag_q[f_idx] == f_tag);

    always_comb begin
        pred = '0;
        if (f_hit) begin
            case (btb_cf_q[f_idx])
                CF_BRANCH: begin
                    if (btb_cnt_q[f_idx][1]) begin
                        pred.cf           = CF_BRANCH;
                        pred.predict_addr = btb_tgt_q[f_idx];
                    end
                end
                CF_JALR: begin
                    pred.cf           = CF_JALR;
                    pred.predict_addr = btb_tgt_q[f_idx];
                end
                CF_RET: begin
                    if (ras_cnt_q != '0) begin
                        pred.cf           = CF_RET;
                        pred.predict_addr = ras_q[ras_ptr_m1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bpu_valid_d = fetch_valid_i && !flush_i;
        bpu_d       = '0;
        if (bpu_valid_d) begin
            bpu_d = pred;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bpu_valid_q <= 1'b0;
            bpu_q       <= '0;
        end else begin
            bpu_valid_q <= bpu_valid_d;
            bpu_q       <= bpu_d;
        end
    end

    assign bpu_valid_o = bpu_valid_q;
    assign bpu_o       = bpu_q;

    // ------------------------------------------------------------
    // BTB update from execute (applied even during a flush)
    // ------------------------------------------------------------
    assign b_idx = bju_i.pc[IDX:1];
    assign b_tag = bju_i.pc[31:IDX+1];
    assign b_hit = btb_vld_q[b_idx] && (btb_tag_q[b_idx] == b_tag);

    assign b_br     = bju_i.valid && (bju_i.cf == CF_BRANCH);
    assign br_upd   = b_br && b_hit;
    assign br_alloc = b_br && !b_hit && bju_i.is_taken;
    assign ind_wr   = bju_i.valid && bju_i.is_mispredict &&
                      ((bju_i.cf == CF_JALR) || (bju_i.cf == CF_RET));

    always_comb begin
        cnt_nxt = btb_cnt_q[b_idx];
        if (bju_i.is_taken) begin
            if (cnt_nxt != 2'd3) cnt_nxt = cnt_nxt + 2'd1;
        end else begin
            if (cnt_nxt != 2'd0) cnt_nxt = cnt_nxt - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_vld_q[i] <= 1'b0;
                btb_tag_q[i] <= '0;
                btb_cf_q[i]  <= CF_NONE;
                btb_tgt_q[i] <= '0;
                btb_cnt_q[i] <= 2'd0;
            end
        end else if (br_alloc || ind_wr) begin
            btb_vld_q[b_idx] <= 1'b1;
            btb_tag_q[b_idx] <= b_tag;
            btb_cf_q[b_idx]  <= bju_i.cf;
            btb_tgt_q[b_idx] <= bju_i.target_address;
            // A fresh branch starts weakly taken
            btb_cnt_q[b_idx] <= br_alloc ? 2'd2 : 2'd0;
        end else if (br_upd) begin
            btb_cnt_q[b_idx] <= cnt_nxt;
            if (bju_i.is_taken) begin
                btb_tgt_q[b_idx] <= bju_i.target_address;
            end
        end
    end

    // ------------------------------------------------------------
    // RAS control
    // ------------------------------------------------------------
    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ras_we    = 1'b0;
        ras_waddr = ras_ptr_q;
        if (flush_i) begin
            ras_ptr_d = '0;
            ras_cnt_d = '0;
        end else if (ras_push_i && (!ras_pop_i || ras_cnt_q == '0)) begin
            // Plain push; push+pop on an empty stack behaves the same
            ras_we    = 1'b1;
            ras_waddr = ras_ptr_q;
            ras_ptr_d = ras_ptr_q + PW'(1);
            if (ras_cnt_q != CW'(RAS_DEPTH)) begin
                ras_cnt_d = ras_cnt_q + CW'(1);
            end
        end else if (ras_push_i) begin
            // Call in the same slot as a return: replace the top
            ras_we    = 1'b1;
            ras_waddr = ras_ptr_m1;
        end else if (ras_pop_i && ras_cnt_q != '0) begin
            ras_ptr_d = ras_ptr_m1;
            ras_cnt_d = ras_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (ras_we) begin
            ras_q[ras_waddr] <= ras_push_addr_i;
        end
    end

endmodule
